// File: rtl/chacha_block_core.sv
// chacha_block_core
// Iterative ChaCha permutation engine. IDLE accepts a 16-word state. RUN
// applies one half-round per clock using four quarter-round units in
// parallel: columns on even counter values, diagonals on odd ones. DONE
// holds the result until the sink takes it.
//
// Optional feature, macro CHACHA_FEEDFWD_EN:
//   defined   - the accepted input is kept and added word-wise onto the
//               permuted state (the full ChaCha block function).
//   undefined - the raw permuted state is output and no input copy is kept.
//
// Parameters:
//   ROUNDS     total rounds per block, even, 2..30 (20 gives ChaCha20)
// Ports:
//   g_clk      clock, all state changes on the rising edge
//   g_resetn   asynchronous active-low reset, drops any in-flight block
//   in_valid   source offers in_state
//   in_ready   high only in IDLE (registered)
//   in_state   16 x 32-bit words, word i at [32i+31:32i]
//   out_valid  out_state holds a finished block (registered)
//   out_ready  sink takes the block this cycle
//   out_state  result words, same ordering; all zeros while out_valid is low
//   busy       high in RUN and DONE
module chacha_block_core #(
  parameter int ROUNDS = 20
) (
  input  logic         g_clk,
  input  logic         g_resetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] out_state,
  output logic         busy
);

  localparam int CW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

  typedef logic [15:0][31:0] state_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
  } qr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_e;

  fsm_e          state_q;
  logic [CW-1:0] cnt_q;
  state_t        working_q;
  state_t        working_d;
  state_t        result;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          busy_q;
  logic          diagRound;
  logic          lastRound;
  qr_t           qIn  [4];
  qr_t           qOut [4];

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic qr_t quarterRound(input qr_t x);
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    a = x.a;
    b = x.b;
    c = x.c;
    d = x.d;
    a = a + b; d = rotl(d ^ a, 16);
    c = c + d; b = rotl(b ^ c, 12);
    a = a + b; d = rotl(d ^ a, 8);
    c = c + d; b = rotl(b ^ c, 7);
    return {a, b, c, d};
  endfunction

  assign diagRound = cnt_q[0];
  assign lastRound = (cnt_q == CW'(ROUNDS - 1));

  // Four quarter-round units shared by column and diagonal rounds. Unit j
  // always owns word j as 'a'; in a diagonal round its b/c/d words are
  // rotated by 1/2/3 positions within their rows, so the write-back of row
  // word k comes from unit (k-1)/(k-2)/(k-3) mod 4 respectively.
  for (genvar j = 0; j < 4; j++) begin : g_unit
    assign qIn[j] = diagRound
      ? {working_q[j], working_q[4 + (j + 1) % 4],
         working_q[8 + (j + 2) % 4], working_q[12 + (j + 3) % 4]}
      : {working_q[j], working_q[4 + j], working_q[8 + j], working_q[12 + j]};

    assign qOut[j] = quarterRound(qIn[j]);

    assign working_d[j]      = qOut[j].a;
    assign working_d[4 + j]  = diagRound ? qOut[(j + 3) % 4].b : qOut[j].b;
    assign working_d[8 + j]  = diagRound ? qOut[(j + 2) % 4].c : qOut[j].c;
    assign working_d[12 + j] = diagRound ? qOut[(j + 1) % 4].d : qOut[j].d;
  end

`ifdef CHACHA_FEEDFWD_EN
  state_t saved_q;

  // Feed-forward: add the original input back onto the permuted state.
  for (genvar i = 0; i < 16; i++) begin : g_ffwd
    assign result[i] = working_q[i] + saved_q[i];
  end
`else
  assign result = working_q;
`endif

  // Control FSM plus datapath registers. in_ready/out_valid/busy are
  // registered copies of the state decode so they change exactly with it;
  // in_ready stays low during reset and rises on the first edge after it.
  // The counter stops at ROUNDS-1 rather than wrapping.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      working_q   <= '0;
`ifdef CHACHA_FEEDFWD_EN
      saved_q     <= '0;
`endif
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            working_q  <= in_state;
`ifdef CHACHA_FEEDFWD_EN
            saved_q    <= in_state;
`endif
            cnt_q      <= '0;
            state_q    <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          working_q <= working_d;
          if (lastRound) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_state = out_valid_q ? result : '0;

endmodule

// File: tb/tb_chacha_block_core.sv
// tb_chacha_block_core
// Self-checking bench for chacha_block_core. A ROUNDS=20 instance runs the
// RFC 8439 vector, backpressure, random blocks, back-to-back blocks and
// resets in RUN and DONE; a ROUNDS=8 instance checks latency. Expected
// data comes from a double-round reference of the ChaCha permutation.
module tb_chacha_block_core;

  localparam int ROUNDS_A   = 20;
  localparam int ROUNDS_B   = 8;
  localparam int WAIT_LIMIT = 200;

  // Quarter-round word groups: four column groups then four diagonal groups.
  localparam int QIDX [8][4] = '{
    '{0, 4,  8, 12}, '{1, 5,  9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
    '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7,  8, 13}, '{3, 4,  9, 14}
  };

  logic         g_clk;
  logic         g_resetn;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [511:0] out_state;
  logic         busy;

  logic         inValidB;
  logic         inReadyB;
  logic [511:0] inStateB;
  logic         outValidB;
  logic         outReadyB;
  logic [511:0] outStateB;
  logic         busyB;

  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  logic [511:0] lastOut;

  chacha_block_core #(.ROUNDS(ROUNDS_A)) dut (
    .g_clk     (g_clk),
    .g_resetn  (g_resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  chacha_block_core #(.ROUNDS(ROUNDS_B)) dutB (
    .g_clk     (g_clk),
    .g_resetn  (g_resetn),
    .in_valid  (inValidB),
    .in_ready  (inReadyB),
    .in_state  (inStateB),
    .out_valid (outValidB),
    .out_ready (outReadyB),
    .out_state (outStateB),
    .busy      (busyB)
  );

  // Free-running 10 ns clock.
  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  // Edge counter used to measure latency from the accepting edge.
  always @(posedge g_clk) cyc <= cyc + 1;

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] rotl32(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  // ChaCha permutation as RFC 8439 writes it: rounds/2 double rounds, each
  // the four column quarter-rounds followed by the four diagonal ones.
  function automatic logic [511:0] refBlock(input logic [511:0] s, input int rounds);
    logic [31:0]  x [16];
    logic [31:0]  a;
    logic [31:0]  b;
    logic [31:0]  c;
    logic [31:0]  d;
    logic [511:0] r;
    for (int i = 0; i < 16; i++) x[i] = s[32*i +: 32];
    for (int dr = 0; dr < rounds / 2; dr++) begin
      for (int q = 0; q < 8; q++) begin
        a = x[QIDX[q][0]];
        b = x[QIDX[q][1]];
        c = x[QIDX[q][2]];
        d = x[QIDX[q][3]];
        a += b; d ^= a; d = rotl32(d, 16);
        c += d; b ^= c; b = rotl32(b, 12);
        a += b; d ^= a; d = rotl32(d, 8);
        c += d; b ^= c; b = rotl32(b, 7);
        x[QIDX[q][0]] = a;
        x[QIDX[q][1]] = b;
        x[QIDX[q][2]] = c;
        x[QIDX[q][3]] = d;
      end
    end
    for (int i = 0; i < 16; i++) begin
`ifdef CHACHA_FEEDFWD_EN
      r[32*i +: 32] = x[i] + s[32*i +: 32];
`else
      r[32*i +: 32] = x[i];
`endif
    end
    return r;
  endfunction

  // RFC 8439 2.3.2 state: key 00..1f, nonce 00000009 0000004a 00000000.
  function automatic logic [511:0] rfcBlock(input logic [31:0] blockCounter);
    logic [31:0]  w [16];
    logic [511:0] r;
    w = '{32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574,
          32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
          32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
          32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000};
    w[12] = blockCounter;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = w[i];
    return r;
  endfunction

  function automatic logic [511:0] randBlock();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  task automatic stepCycle();
    @(posedge g_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %b, expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkInt(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Offer a block and return the edge count of the accepting edge.
  task automatic applyStimulus(input logic [511:0] s, input bit keepValid, output int acceptCyc);
    int n;
    n = 0;
    in_state = s;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < WAIT_LIMIT) begin
      stepCycle();
      n++;
    end
    checkBit("accept in_ready", in_ready, 1'b1);
    stepCycle();
    acceptCyc = cyc;
    if (!keepValid) begin
      in_valid = 1'b0;
      in_state = randBlock();
    end
  endtask

  // Wait for a result, check latency/data, optionally stall, then take it.
  task automatic drainBlock(input string tag, input logic [511:0] expected, input int acceptCyc,
                            input int holdCycles, input bit randomReady);
    int n;
    bit runOk;
    bit holdOk;
    n = 0;
    runOk = 1'b1;
    while (out_valid !== 1'b1 && n < WAIT_LIMIT) begin
      if (in_ready !== 1'b0 || busy !== 1'b1 || out_state !== '0) runOk = 1'b0;
      if (randomReady) out_ready = 1'($urandom_range(0, 1));
      stepCycle();
      n++;
    end
    out_ready = 1'b0;
    if (in_ready !== 1'b0 || busy !== 1'b1) runOk = 1'b0;
    lastOut = out_state;
    checkInt({tag, " latency"}, cyc - acceptCyc, ROUNDS_A);
    checkBit({tag, " run flags"}, runOk, 1'b1);
    checkOutput({tag, " data"}, out_state, expected);
    holdOk = 1'b1;
    for (int h = 0; h < holdCycles; h++) begin
      stepCycle();
      if (out_valid !== 1'b1 || out_state !== expected || in_ready !== 1'b0 || busy !== 1'b1)
        holdOk = 1'b0;
    end
    if (holdCycles > 0) checkBit({tag, " stall hold"}, holdOk, 1'b1);
    out_ready = 1'b1;
    stepCycle();
    out_ready = 1'b0;
    checkBit({tag, " released out_valid"}, out_valid, 1'b0);
    checkOutput({tag, " released out_state"}, out_state, '0);
    checkBit({tag, " released in_ready"}, in_ready, 1'b1);
    checkBit({tag, " released busy"}, busy, 1'b0);
  endtask

  initial begin
    logic [511:0] blk;
    logic [511:0] blk2;
    logic [511:0] expB;
    int           acc;
    int           acc2;
    int           n;
    bit           runOk;

    g_resetn  = 1'b1;
    in_valid  = 1'b0;
    in_state  = '0;
    out_ready = 1'b0;
    inValidB  = 1'b0;
    inStateB  = '0;
    outReadyB = 1'b0;

    // Power-on reset.
    #2 g_resetn = 1'b0;
    repeat (3) stepCycle();
    checkBit("reset in_ready", in_ready, 1'b0);
    checkBit("reset out_valid", out_valid, 1'b0);
    checkBit("reset busy", busy, 1'b0);
    checkOutput("reset out_state", out_state, '0);
    @(negedge g_clk);
    g_resetn = 1'b1;
    stepCycle();
    checkBit("in_ready after reset", in_ready, 1'b1);

    // ROUNDS=8 latency on the second instance.
    $display("[TB] ROUNDS=8 latency");
    inStateB = rfcBlock(32'd1);
    expB = refBlock(inStateB, ROUNDS_B);
    inValidB = 1'b1;
    n = 0;
    while (inReadyB !== 1'b1 && n < WAIT_LIMIT) begin
      stepCycle();
      n++;
    end
    checkBit("r8 accept in_ready", inReadyB, 1'b1);
    stepCycle();
    acc = cyc;
    inValidB = 1'b0;
    n = 0;
    runOk = 1'b1;
    while (outValidB !== 1'b1 && n < WAIT_LIMIT) begin
      if (inReadyB !== 1'b0 || busyB !== 1'b1) runOk = 1'b0;
      stepCycle();
      n++;
    end
    checkInt("r8 latency", cyc - acc, ROUNDS_B);
    checkBit("r8 in_ready low during run", runOk, 1'b1);
    checkBit("r8 in_ready low in done", inReadyB, 1'b0);
    checkOutput("r8 data", outStateB, expB);
    outReadyB = 1'b1;
    stepCycle();
    outReadyB = 1'b0;
    checkBit("r8 released out_valid", outValidB, 1'b0);
    checkBit("r8 released in_ready", inReadyB, 1'b1);

    // RFC 8439 vector.
    $display("[TB] RFC 8439 vector");
    blk = rfcBlock(32'd1);
    applyStimulus(blk, 1'b0, acc);
    drainBlock("rfc", refBlock(blk, ROUNDS_A), acc, 0, 1'b0);
`ifdef CHACHA_FEEDFWD_EN
    checkOutput("rfc word0", {480'd0, lastOut[31:0]}, {480'd0, 32'he4e7f110});
`else
    checkOutput("rfc word0", {480'd0, lastOut[31:0]}, {480'd0, 32'h837778ab});
    checkOutput("rfc word1", {480'd0, lastOut[63:32]}, {480'd0, 32'he238d763});
`endif

    // Backpressure: five stalled cycles in DONE.
    $display("[TB] backpressure");
    blk = randBlock();
    applyStimulus(blk, 1'b0, acc);
    drainBlock("backpressure", refBlock(blk, ROUNDS_A), acc, 5, 1'b0);

    // Random blocks, random out_ready during RUN, random stalls.
    $display("[TB] random blocks");
    for (int k = 0; k < 4; k++) begin
      blk = randBlock();
      applyStimulus(blk, 1'b0, acc);
      drainBlock($sformatf("random%0d", k), refBlock(blk, ROUNDS_A), acc,
                 int'($urandom_range(0, 3)), 1'b1);
    end

    // Back-to-back with in_valid held high throughout.
    $display("[TB] back-to-back");
    blk  = rfcBlock(32'd1);
    blk2 = rfcBlock(32'd2);
    applyStimulus(blk, 1'b1, acc);
    in_state = blk2;
    drainBlock("b2b first", refBlock(blk, ROUNDS_A), acc, 0, 1'b0);
    applyStimulus(blk2, 1'b0, acc2);
    drainBlock("b2b second", refBlock(blk2, ROUNDS_A), acc2, 0, 1'b0);

    // Reset in RUN at round 7, then a fresh RFC block.
    $display("[TB] reset during run");
    blk = rfcBlock(32'd1);
    applyStimulus(randBlock(), 1'b0, acc);
    repeat (7) stepCycle();
    checkBit("pre-reset busy", busy, 1'b1);
    #2 g_resetn = 1'b0;
    #1;
    checkBit("run reset out_valid", out_valid, 1'b0);
    checkBit("run reset busy", busy, 1'b0);
    checkBit("run reset in_ready", in_ready, 1'b0);
    checkOutput("run reset out_state", out_state, '0);
    @(negedge g_clk);
    g_resetn = 1'b1;
    stepCycle();
    checkBit("run reset in_ready after", in_ready, 1'b1);
    applyStimulus(blk, 1'b0, acc);
    drainBlock("after reset", refBlock(blk, ROUNDS_A), acc, 0, 1'b0);
`ifdef CHACHA_FEEDFWD_EN
    checkOutput("after reset word0", {480'd0, lastOut[31:0]}, {480'd0, 32'he4e7f110});
`else
    checkOutput("after reset word0", {480'd0, lastOut[31:0]}, {480'd0, 32'h837778ab});
`endif

    // Reset while a result waits in DONE.
    $display("[TB] reset in done");
    applyStimulus(randBlock(), 1'b0, acc);
    n = 0;
    while (out_valid !== 1'b1 && n < WAIT_LIMIT) begin
      stepCycle();
      n++;
    end
    checkBit("pre-reset done out_valid", out_valid, 1'b1);
    #2 g_resetn = 1'b0;
    #1;
    checkBit("done reset out_valid", out_valid, 1'b0);
    checkOutput("done reset out_state", out_state, '0);
    checkBit("done reset busy", busy, 1'b0);
    @(negedge g_clk);
    g_resetn = 1'b1;
    stepCycle();
    checkBit("done reset in_ready after", in_ready, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
